// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning slice: FSM encoding and
// the width helper used to validate counter sizing at elaboration.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Number of bits needed to represent v (at least 1).
  function automatic int unsigned bits_for(input longint unsigned v);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 64; i++) begin
      if ((v >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronise, debounce with a stable-sample window,
// and emit registered press / release / long-press strobes plus the clean level.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("btn_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (bits_for(longint'(LONG_CYCLES)) > CNT_W) begin : g_bad_width
    $error("btn_debounce: CNT_W too narrow to hold LONG_CYCLES");
  end

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);

  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold;
  logic [CNT_W-1:0] hold_inc;
  logic             hold_hit;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s2)
  );

  // Saturating hold step, shared by PRESSED and the bounce return from RELEASE_WAIT.
  always_comb begin
    hold_inc = hold;
    hold_hit = 1'b0;
    if (hold != HOLD_MAX) begin
      hold_inc = hold + CNT_W'(1);
      hold_hit = (hold == HOLD_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      hold          <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          hold       <= hold_inc;
          long_pulse <= hold_hit;
          if (!s2) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          // Hold count is frozen while a release is pending and resumes on bounce.
          if (s2) begin
            state      <= PRESSED;
            cnt        <= '0;
            hold       <= hold_inc;
            long_pulse <= hold_hit;
          end else if (cnt == DB_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            hold          <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
